// File: rtl/ysyx_22050243_lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - FSM state encoding
//   - funct3 codes for loads and stores
//   - byte-lane size masks plus helpers for legality and alignment checks
package ysyx_22050243_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0f;
  localparam logic [7:0] MASK_D = 8'hff;

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return MASK_B;
      2'b01:   return MASK_H;
      2'b10:   return MASK_W;
      default: return MASK_D;
    endcase
  endfunction

  // Stores only have four sizes; loads reserve 111.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return f3[2];
    return (f3 == 3'b111);
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050243_lsu_align.sv
// Combinational lane logic for the LSU.
//   funct3, off  : latched access size/sign and byte offset within the 64-bit word
//   wen          : 1 = store (read requests drive a zero mask)
//   wdata        : raw store data; wdata_sh is it shifted onto its byte lanes
//   wmask        : byte-lane enables for the bus request
//   rsp_rdata    : aligned 64-bit bus read data; load_data is the extended result
module ysyx_22050243_lsu_align
  import ysyx_22050243_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  off,
  input  logic        wen,
  input  logic [63:0] wdata,
  input  logic [63:0] rsp_rdata,
  output logic [7:0]  wmask,
  output logic [63:0] wdata_sh,
  output logic [63:0] load_data
);

  logic [5:0]  bit_off;
  logic [63:0] rsh;

  assign bit_off  = {off, 3'b000};
  assign wmask    = wen ? (size_mask(funct3[1:0]) << off) : 8'h00;
  assign wdata_sh = wdata << bit_off;
  assign rsh      = rsp_rdata >> bit_off;

  always_comb begin
    load_data = '0;
    case (funct3)
      LB:      load_data = {{56{rsh[7]}},  rsh[7:0]};
      LH:      load_data = {{48{rsh[15]}}, rsh[15:0]};
      LW:      load_data = {{32{rsh[31]}}, rsh[31:0]};
      LD:      load_data = rsh;
      LBU:     load_data = {56'd0, rsh[7:0]};
      LHU:     load_data = {48'd0, rsh[15:0]};
      LWU:     load_data = {32'd0, rsh[31:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22050243_lsu.sv
// Load/store unit: turns decoder mem_r/mem_w + funct3 into one valid/ready
// bus transaction, stalls the core while it is in flight and pulses done
// with the extended load result.
//   clk, rst_n            : core clock, async active-low reset
//   mem_r, mem_w, funct3  : decoder memory control
//   addr, wdata           : effective address and rs2 store data
//   stall, done, rdata    : pipeline freeze, completion pulse, load result
//   misalign, access_err  : error pulses coincident with done
//   bus_req_*             : request channel (address word-aligned)
//   bus_rsp_*             : read data / write acknowledge
// Data width is fixed at 64 bits (8 byte lanes); DW exists for port sizing.
module ysyx_22050243_lsu
  import ysyx_22050243_lsu_pkg::*;
#(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_r,
  input  logic          mem_w,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          stall,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          misalign,
  output logic          access_err,
  output logic          bus_req_valid,
  input  logic          bus_req_ready,
  output logic [AW-1:0] bus_req_addr,
  output logic          bus_req_wen,
  output logic [7:0]    bus_req_wmask,
  output logic [DW-1:0] bus_req_wdata,
  input  logic          bus_rsp_valid,
  input  logic [DW-1:0] bus_rsp_rdata
);

  lsu_state_e    state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [2:0]    f3_q;
  logic          wen_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          mis_q, err_q;

  logic          start, illegal, mis;
  logic [7:0]    wmask;
  logic [DW-1:0] wdata_sh, load_data;

  assign start   = (state_q == IDLE) & (mem_r | mem_w);
  assign illegal = (mem_r & mem_w) | f3_illegal(mem_w, funct3);
  // Alignment only matters once the access is known legal.
  assign mis     = ~illegal & misaligned(funct3[1:0], addr[2:0]);

  ysyx_22050243_lsu_align u_align (
    .funct3    (f3_q),
    .off       (addr_q[2:0]),
    .wen       (wen_q),
    .wdata     (wdata_q),
    .rsp_rdata (bus_rsp_rdata),
    .wmask     (wmask),
    .wdata_sh  (wdata_sh),
    .load_data (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = start;
        if (start) state_d = (illegal | mis) ? DONE : REQ;
      end
      REQ: begin
        stall = 1'b1;
        if (bus_req_ready) state_d = RSP;
      end
      RSP: begin
        stall = 1'b1;
        if (bus_rsp_valid) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      f3_q    <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (start) begin
        addr_q  <= addr;
        f3_q    <= funct3;
        wen_q   <= mem_w;
        wdata_q <= wdata;
        err_q   <= illegal;
        mis_q   <= mis;
        // Rejected accesses report zero data alongside the error pulse.
        if (illegal | mis) rdata_q <= '0;
      end
      // Store acks leave rdata untouched.
      if (state_q == RSP && bus_rsp_valid && !wen_q) rdata_q <= load_data;
    end
  end

  assign done          = (state_q == DONE);
  assign misalign      = done & mis_q;
  assign access_err    = done & err_q;
  assign rdata         = rdata_q;

  // Request fields come straight from latched state so they stay stable
  // for however long the bus holds off ready.
  assign bus_req_valid = (state_q == REQ);
  assign bus_req_addr  = {addr_q[AW-1:3], 3'b000};
  assign bus_req_wen   = wen_q;
  assign bus_req_wmask = wmask;
  assign bus_req_wdata = wdata_sh;

endmodule

// File: tb/tb_ysyx_22050243_lsu.sv
module tb_ysyx_22050243_lsu;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_r = 1'b0, mem_w = 1'b0;
  logic [2:0]    funct3 = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          stall, done, misalign, access_err;
  logic [DW-1:0] rdata;
  logic          bus_req_valid, bus_req_ready, bus_req_wen;
  logic [AW-1:0] bus_req_addr;
  logic [7:0]    bus_req_wmask;
  logic [DW-1:0] bus_req_wdata;
  logic          bus_rsp_valid;
  logic [DW-1:0] bus_rsp_rdata;

  ysyx_22050243_lsu #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .mem_r(mem_r), .mem_w(mem_w), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .misalign(misalign), .access_err(access_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_addr(bus_req_addr), .bus_req_wen(bus_req_wen),
    .bus_req_wmask(bus_req_wmask), .bus_req_wdata(bus_req_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] rdata; logic mis; logic err; } sb_t;
  typedef struct { logic [63:0] addr; logic wen; logic [7:0] wmask; logic [63:0] wdata; } bus_t;

  sb_t         sbq[$];
  bus_t        bq[$];
  int          n_tests = 0, n_fail = 0;
  logic [63:0] rdata_model = '0;
  logic [7:0]  ref_mem [1024];   // byte-addressed reference memory
  logic [63:0] bus_mem [128];    // word-addressed memory behind the bus
  int          ready_low = 0;
  bit          ready_rand = 0;
  int          rsp_force = 0;    // <0: random response delay
  int          rsp_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  task automatic set_word(input logic [63:0] a, input logic [63:0] v);
    bus_mem[a[9:3]] = v;
    for (int i = 0; i < 8; i++) ref_mem[int'({a[9:3], 3'(i)})] = v[8*i +: 8];
  endtask

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a);
    int n;
    logic [63:0] v;
    n = 1 << f3[1:0];
    v = '0;
    for (int i = 0; i < n; i++) v |= 64'(ref_mem[int'((a + 64'(i)) & 64'h3ff)]) << (8*i);
    if (!f3[2] && n < 8 && v[8*n-1]) v |= {64{1'b1}} << (8*n);
    return v;
  endfunction

  // Bus-side memory: ready generation, write merge, delayed response.
  initial begin
    bit          pend;
    int          dly;
    logic [63:0] rd;
    bus_req_ready = 1'b1;
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = '0;
    pend = 0; dly = 0; rd = '0;
    forever begin
      @(negedge clk);
      if (bus_req_valid && bus_req_ready) begin
        if (bus_req_wen) begin
          for (int i = 0; i < 8; i++)
            if (bus_req_wmask[i]) bus_mem[bus_req_addr[9:3]][8*i +: 8] = bus_req_wdata[8*i +: 8];
          rd = {$urandom, $urandom};
        end else rd = bus_mem[bus_req_addr[9:3]];
        pend = 1;
        dly = (rsp_force >= 0) ? rsp_force : int'($urandom_range(0, 2));
      end
      @(posedge clk); #1;
      bus_rsp_valid = 1'b0;
      bus_rsp_rdata = {$urandom, $urandom};
      if (pend) begin
        if (dly == 0) begin
          bus_rsp_valid = 1'b1; bus_rsp_rdata = rd; pend = 0; rsp_count++;
        end else dly--;
      end
      if (bus_req_valid && ready_low > 0) begin
        bus_req_ready = 1'b0; ready_low--;
      end else bus_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Completion scoreboard.
  initial forever begin
    sb_t s;
    @(negedge clk);
    if (done) begin
      if (sbq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_done: rdata 0x%h with no access outstanding", rdata);
      end else begin
        s = sbq.pop_front();
        chk("rdata", rdata, s.rdata);
        chk("misalign", misalign, s.mis);
        chk("access_err", access_err, s.err);
      end
    end
  end

  // Request-channel scoreboard, compared at each handshake.
  initial forever begin
    bus_t b;
    @(negedge clk);
    if (rst_n && bus_req_valid && bus_req_ready) begin
      if (bq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_req: addr 0x%h", bus_req_addr);
      end else begin
        b = bq.pop_front();
        chk("req_addr", bus_req_addr, b.addr);
        chk("req_wen", bus_req_wen, b.wen);
        chk("req_wmask", bus_req_wmask, b.wmask);
        if (b.wen) chk("req_wdata", bus_req_wdata, b.wdata);
      end
    end
  end

  // One access; expectations come from the byte-level reference memory.
  task automatic do_access(input logic r, input logic w, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] wd,
                           input int exp_lat, input int exp_vld);
    int n, off, lat, vld_cnt;
    logic ill, mis;
    sb_t s;
    bus_t b;
    n   = 1 << f3[1:0];
    off = int'(a[2:0]);
    ill = (r && w) || (r && !w && f3 == 3'd7) || (w && !r && f3 >= 3'd4);
    mis = !ill && ((off % n) != 0);
    if (ill || mis) rdata_model = '0;
    else if (r) begin
      rdata_model = ref_load(f3, a);
      b.addr = a & ~64'h7; b.wen = 1'b0; b.wmask = 8'h00; b.wdata = '0;
      bq.push_back(b);
    end else begin
      for (int i = 0; i < n; i++) ref_mem[int'((a + 64'(i)) & 64'h3ff)] = wd[8*i +: 8];
      b.addr = a & ~64'h7; b.wen = 1'b1;
      b.wmask = 8'(((1 << n) - 1) << off);
      b.wdata = wd << (8*off);
      bq.push_back(b);
    end
    s.rdata = rdata_model; s.mis = mis; s.err = ill;
    sbq.push_back(s);

    mem_r = r; mem_w = w; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    chk("stall_start", stall, 1'b1);
    @(posedge clk); #1;
    mem_r = 1'b0; mem_w = 1'b0;
    funct3 = 3'($urandom); addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    lat = 1; vld_cnt = 0;
    forever begin
      @(negedge clk);
      if (bus_req_valid) vld_cnt++;
      if (done) break;
      chk("stall_busy", stall, 1'b1);
      lat++;
      if (lat > 300) begin
        $display("FAIL timeout: no done within 300 cycles");
        $fatal(1);
      end
    end
    chk("stall_done", stall, 1'b0);
    if (exp_lat > 0) chk("latency", 64'(lat), 64'(exp_lat));
    if (exp_vld >= 0) chk("req_valid_cycles", 64'(vld_cnt), 64'(exp_vld));
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, done_cnt;
    bus_t b;
    for (int w = 0; w < 128; w++) set_word(64'(w) << 3, {$urandom, $urandom});

    #12;
    chk("rst_stall", stall, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_valid", bus_req_valid, 1'b0);
    chk("rst_rdata", rdata, '0);
    chk("rst_addr", bus_req_addr, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases with an always-ready bus and immediate responses.
    set_word(BASE, 64'h0000_0000_8000_0000);
    do_access(1'b1, 1'b0, 3'b000, BASE + 3, '0, 3, 1);                 // lb
    do_access(1'b0, 1'b1, 3'b001, BASE + 6, 64'h1234, 3, 1);           // sh
    do_access(1'b1, 1'b0, 3'b011, BASE + 4, '0, 1, 0);                 // ld misaligned
    set_word(64'h10, 64'hFFFF_FFFF_DEAD_BEEF);
    ready_low = 3;
    do_access(1'b1, 1'b0, 3'b110, 64'h10, '0, 6, 4);                   // lwu, ready stalls
    do_access(1'b1, 1'b1, 3'b011, BASE, 64'h55, 1, 0);                 // both r and w
    do_access(1'b1, 1'b0, 3'b111, BASE, '0, 1, 0);                     // load f3 111
    do_access(1'b0, 1'b1, 3'b100, BASE, 64'h77, 1, 0);                 // store f3 100
    do_access(1'b1, 1'b0, 3'b011, BASE + 8, '0, 3, 1);                 // ld aligned

    // Reset while waiting in RSP; the late response must be ignored.
    rsp_force = 5;
    b.addr = BASE + 8; b.wen = 1'b0; b.wmask = 8'h00; b.wdata = '0;
    bq.push_back(b);
    mem_r = 1'b1; funct3 = 3'b000; addr = BASE + 8;
    @(posedge clk); #1; mem_r = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rsp_wait_stall", stall, 1'b1);
    chk("rsp_wait_valid", bus_req_valid, 1'b0);
    c0 = rsp_count;
    #2 rst_n = 1'b0; #1;
    chk("arst_stall", stall, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_valid", bus_req_valid, 1'b0);
    chk("arst_addr", bus_req_addr, '0);
    chk("arst_wmask", bus_req_wmask, 8'h00);
    chk("arst_rdata", rdata, '0);
    chk("arst_err", {misalign, access_err}, 2'b00);
    rdata_model = '0;
    @(posedge clk); @(negedge clk); #2 rst_n = 1'b1;
    done_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || stall) done_cnt++;
    end
    chk("late_rsp_seen", 64'(rsp_count - c0), 64'd1);
    chk("late_rsp_ignored", 64'(done_cnt), 64'd0);
    rsp_force = 0;
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 3'b000, BASE + 17, '0, 3, 1);

    // Randomized traffic over a small window so loads see earlier stores.
    ready_rand = 1; rsp_force = -1;
    for (int k = 0; k < 150; k++) begin
      int op, n;
      logic [2:0] f3;
      logic [63:0] a;
      op = int'($urandom_range(0, 19));
      f3 = 3'($urandom);
      n = 1 << f3[1:0];
      a = BASE + 64'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a = a & ~64'(n - 1);
      if (op == 0)      do_access(1'b1, 1'b1, f3, a, {$urandom, $urandom}, 0, -1);
      else if (op < 10) do_access(1'b1, 1'b0, f3, a, '0, 0, -1);
      else              do_access(1'b0, 1'b1, f3, a, {$urandom, $urandom}, 0, -1);
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end

    repeat (5) @(posedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    chk("bus_drained", 64'(bq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050243_lsu.md
Name: ysyx_22050243_lsu

Overview:
Load/store unit that consumes the decoder's memory-control outputs (mem_r, mem_w, funct3) together with the ALU-computed address and rs2 data. It runs each load or store as a multi-cycle transaction on a valid/ready data-memory bus. While the transaction is in flight it stalls the core. It returns sign- or zero-extended load data to the register write-back mux (mem2reg = 001). It sits between the ID/EX control path and the data-memory/AXI bridge.

Parameters:
AW, 64, address width
DW, 64, data width; fixed at 64 (8 byte lanes)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
mem_r  in  1  load request from decoder
mem_w  in  1  store request from decoder
funct3  in  3  access size/sign
addr  in  AW  effective address (rs1 + imm)
wdata  in  DW  store data (rs2)
stall  out  1  freeze PC/pipeline
done  out  1  one-cycle completion pulse; rdata valid
rdata  out  DW  extended load result
misalign  out  1  pulse with done: misaligned access, no bus activity
access_err  out  1  pulse with done: illegal funct3, or mem_r and mem_w both high
bus_req_valid  out  1  request valid
bus_req_ready  in  1  memory accepts request
bus_req_addr  out  AW  addr with [2:0] forced to 0
bus_req_wen  out  1  1 = write
bus_req_wmask  out  8  byte-lane enables (0 for reads)
bus_req_wdata  out  DW  lane-shifted store data
bus_rsp_valid  in  1  read data / write acknowledge valid
bus_rsp_rdata  in  DW  aligned 64-bit read data

Behaviour:
- Reset (async, rst_n = 0): state IDLE; every output 0; latched fields 0. Asserting reset mid-transaction drops bus_req_valid immediately. A response arriving after reset is ignored.
- start = (mem_r | mem_w) in IDLE.
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE:
  - stall = start (combinational).
  - On start, latch addr, funct3, wdata and direction (wen = mem_w).
  - Illegal cases go to DONE with access_err set:
    - both mem_r and mem_w high;
    - load funct3 = 111;
    - store funct3 >= 100.
  - Misaligned cases go to DONE with misalign set: halfword with addr[0] != 0; word with addr[1:0] != 0; doubleword with addr[2:0] != 0.
  - Otherwise go to REQ.
- REQ:
  - stall = 1; bus_req_valid = 1 (registered). addr, wen, wmask and wdata are held stable until the handshake.
  - On bus_req_ready, go to RSP. Stay in REQ indefinitely while bus_req_ready = 0.
- RSP:
  - stall = 1.
  - bus_rsp_valid is honoured only in RSP; earliest response is the cycle after acceptance.
  - Load: capture bus_rsp_rdata >> (8*addr[2:0]), then extend:
    - funct3 000 lb: sign-extend 8 bits
    - funct3 001 lh: sign-extend 16 bits
    - funct3 010 lw: sign-extend 32 bits
    - funct3 011 ld: full 64 bits
    - funct3 100 lbu, 101 lhu, 110 lwu: zero-extend
  - Store: the response is a write acknowledge; rdata is left unchanged.
  - Go to DONE.
- DONE:
  - done = 1, stall = 0, for exactly one cycle.
  - misalign/access_err are pulsed here if flagged. On error, rdata = 0.
  - Inputs are ignored in this cycle. Next state IDLE; a new access can start the following cycle.
- Store lanes: wmask = size mask << addr[2:0], with size mask sb 0x01, sh 0x03, sw 0x0F, sd 0xFF. wdata is shifted left by 8*addr[2:0].
- Latency, load/store with ready = 1 and immediate response: start cycle N, REQ N+1, RSP N+2, done N+3.
- Latency, error: done and the error pulse at N+1.
- rdata holds its last value until the next load completes.
- Address arithmetic is unsigned with no wrap checks; bus_req_addr = {addr[AW-1:3], 3'b000}.

Decomposition:
- Package ysyx_22050243_lsu_pkg holds:
  - state encoding (IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2, DONE = 2'd3);
  - funct3 constants LB..LWU and SB..SD;
  - size-mask constants.
- One combinational sub-module, ysyx_22050243_lsu_align. It covers store lane shift/mask generation and load shift/extend. The top keeps the FSM and registers.

Test Plan:
1. lb, addr 0x8000_0003, rsp rdata 0x0000_0000_8000_0000 -> bus_req_addr 0x8000_0000, wmask 0, done at start+3, rdata 0xFFFF_FFFF_FFFF_FF80.
2. sh, addr 0x8000_0006, wdata 0x1234 -> wmask 0xC0, bus_req_wdata 0x1234_0000_0000_0000, wen 1; done after ack; stall high 3 cycles.
3. ld at addr 0x8000_0004 -> misalign = 1 and done = 1 at start+1; bus_req_valid never asserted; rdata 0.
4. lwu at addr 0x10, bus_req_ready low 3 cycles, rsp 0xFFFF_FFFF_DEAD_BEEF -> bus_req_valid held 4 cycles with stable fields; rdata 0x0000_0000_DEAD_BEEF; stall high until done.
5. mem_r and mem_w both high, or load funct3 = 111 -> access_err pulse at start+1; no bus request.
6. rst_n low during RSP, then a late bus_rsp_valid -> all outputs 0 asynchronously; FSM in IDLE; late response ignored; next lb completes normally.
